multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control FSM for the multicycle RV32I core. It sequences the single shared ALU, instruction/data memory port, PC and register file across the per-instruction steps: fetch, decode, execute, memory and writeback. It drives the ALU's 4-bit ALUControl and the datapath mux selects and write enables. It waits on a memory-ready handshake and raises a sticky trap on unsupported opcodes.

## Interface
- ALU_CTRL_WIDTH, 4, ALUControl width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- Op  in  7  instruction[6:0] from the instruction register
- Funct3  in  3  instruction[14:12]
- Funct7b5  in  1  instruction[30]
- Zero  in  1  ALU equality flag (SrcA == SrcB)
- AluLt  in  1  ALUResult[0], the comparison result for slt/sltu
- MemReady  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register load enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = Result
- MemWrite  out  1  data store request
- IRWrite  out  1  instruction register and OldPC load enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00 = ALUOut, 01 = read Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 register
- ALUSrcB  out  2  00 = rs2 register, 01 = ImmExt, 10 = constant 4
- ImmSrc  out  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U
- ALUControl  out  4  0000 add, 0001 sub, 0010 sll, 0011 slt, 0100 sltu, 0101 xor, 0110 srl, 0111 sra, 1000 or, 1001 and, 1011 pass SrcB
- InstrDone  out  1  one-cycle pulse on the final state of each instruction
- Illegal  out  1  sticky trap flag

## Operation
- Moore FSM. States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, LUI, AUIPC, JAL, JALR_ADR, JALR_J, BRANCH, TRAP.
- Any output not listed for a state is 0: enables, and selects/ALUControl/ImmSrc at 0.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite and PCWrite are asserted only while MemReady=1.
  - Stays in FETCH until MemReady=1, then goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add. This precomputes the branch/jump target into ALUOut.
  - ImmSrc=011 if Op=1101111, else 010.
  - Next state by Op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 0110111 -> LUI
    - 0010111 -> AUIPC
    - 1101111 -> JAL
    - 1100111 -> JALR_ADR
    - 1100011 -> BRANCH
    - any other Op -> TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. ImmSrc=001 for a store, else 000. Next: MEMWRITE if Op[5]=1, else MEMREAD.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds until MemReady=1, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, InstrDone=1, then FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until MemReady=1. On the ready cycle InstrDone=1 and the next state is FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, then ALUWB.
- ALU decode for EXECR and EXECI, by Funct3:
  - 000: add; sub only in EXECR with Funct7b5=1
  - 001: sll
  - 010: slt
  - 011: sltu
  - 100: xor
  - 101: sra if Funct7b5=1, else srl
  - 110: or
  - 111: and
- LUI: ALUSrcB=01, ImmSrc=100, ALUControl=1011, then ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01, ImmSrc=100, add, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, InstrDone=1, then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then ALUWB.
  - PC takes the target from ALUOut.
  - rd receives OldPC+4.
- JALR_ADR: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, add, then JALR_J.
- JALR_J: same outputs as JAL, then ALUWB.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ResultSrc=00, InstrDone=1, then FETCH.
  - ALUControl: sub for Funct3 00x, slt for 10x, sltu for 11x.
  - PCWrite = taken, where taken is:
    - beq: Zero
    - bne: !Zero
    - blt / bltu: AluLt
    - bge / bgeu: !AluLt
  - Funct3 010 or 011 -> TRAP, with PCWrite=0.
- TRAP: Illegal=1, all enables 0. Remains in TRAP until reset.

## Timing
- rst_n sampled low at a clock edge -> state=FETCH and Illegal=0 after that edge.
- Reset values: all enables 0, except that FETCH asserts IRWrite and PCWrite iff MemReady.
- Reset mid-instruction aborts the instruction; no partial writeback occurs after the reset edge.
- Cycle counts with MemReady=1 every cycle:
  - lw: 5
  - sw, R-type, I-type, lui, auipc, jal: 4
  - jalr: 5
  - branch: 3
- Each cycle MemReady is low in FETCH, MEMREAD or MEMWRITE adds one cycle. Outputs stay stable while waiting.
- InstrDone pulses exactly once per retired instruction and never in TRAP.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with MemReady=0 -> FETCH with all enables 0 and Illegal=0.
- add (Op=0110011, f3=000, f7b5=0) -> FETCH, DECODE, EXECR(ALUControl=0000), ALUWB with RegWrite=1 on cycle 4. With f7b5=1 -> EXECR ALUControl=0001.
- lw with MemReady low for 3 cycles in MEMREAD -> 8 cycles total, one InstrDone, RegWrite with ResultSrc=01.
- beq (f3=000): Zero=1 -> PCWrite=1 in BRANCH. bge (f3=101) with AluLt=1 -> ALUControl=0011 and PCWrite=0.
- srai (Op=0010011, f3=101, f7b5=1) -> ALUControl=0111. lui -> ALUControl=1011 with ImmSrc=100.
- Op=1111111 -> TRAP after DECODE with Illegal=1 held for 10 cycles. Then rst_n=0 for one edge -> Illegal=0 and state FETCH.

Source files
------------

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Main control FSM of the multicycle RV32I core (fetch, decode,
//            execute, memory and writeback sequencing over one shared ALU).
// Revision : 1.0  initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int ALU_CTRL_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                Op,
    input  logic [2:0]                Funct3,
    input  logic                      Funct7b5,
    input  logic                      Zero,
    input  logic                      AluLt,
    input  logic                      MemReady,
    output logic                      PCWrite,
    output logic                      AdrSrc,
    output logic                      MemWrite,
    output logic                      IRWrite,
    output logic                      RegWrite,
    output logic [1:0]                ResultSrc,
    output logic [1:0]                ALUSrcA,
    output logic [1:0]                ALUSrcB,
    output logic [2:0]                ImmSrc,
    output logic [ALU_CTRL_WIDTH-1:0] ALUControl,
    output logic                      InstrDone,
    output logic                      Illegal
);

    localparam logic [3:0] c_fetch    = 4'd0;
    localparam logic [3:0] c_decode   = 4'd1;
    localparam logic [3:0] c_memadr   = 4'd2;
    localparam logic [3:0] c_memread  = 4'd3;
    localparam logic [3:0] c_memwb    = 4'd4;
    localparam logic [3:0] c_memwrite = 4'd5;
    localparam logic [3:0] c_execr    = 4'd6;
    localparam logic [3:0] c_execi    = 4'd7;
    localparam logic [3:0] c_aluwb    = 4'd8;
    localparam logic [3:0] c_lui      = 4'd9;
    localparam logic [3:0] c_auipc    = 4'd10;
    localparam logic [3:0] c_jal      = 4'd11;
    localparam logic [3:0] c_jalr_adr = 4'd12;
    localparam logic [3:0] c_jalr_j   = 4'd13;
    localparam logic [3:0] c_branch   = 4'd14;
    localparam logic [3:0] c_trap     = 4'd15;

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_branch = 7'b1100011;

    localparam logic [3:0] c_alu_add  = 4'b0000;
    localparam logic [3:0] c_alu_sub  = 4'b0001;
    localparam logic [3:0] c_alu_sll  = 4'b0010;
    localparam logic [3:0] c_alu_slt  = 4'b0011;
    localparam logic [3:0] c_alu_sltu = 4'b0100;
    localparam logic [3:0] c_alu_xor  = 4'b0101;
    localparam logic [3:0] c_alu_srl  = 4'b0110;
    localparam logic [3:0] c_alu_sra  = 4'b0111;
    localparam logic [3:0] c_alu_or   = 4'b1000;
    localparam logic [3:0] c_alu_and  = 4'b1001;
    localparam logic [3:0] c_alu_pass = 4'b1011;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [3:0] w_alu;
    logic [3:0] w_alu_ri;
    logic       w_taken;
    logic       w_br_legal;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_fetch;
        end else begin
            r_state <= w_next;
        end
    end

    // Register/immediate ALU decode; sub only exists in the register form.
    always_comb begin
        w_alu_ri = c_alu_add;
        case (Funct3)
            3'b000:  w_alu_ri = (r_state == c_execr && Funct7b5) ? c_alu_sub : c_alu_add;
            3'b001:  w_alu_ri = c_alu_sll;
            3'b010:  w_alu_ri = c_alu_slt;
            3'b011:  w_alu_ri = c_alu_sltu;
            3'b100:  w_alu_ri = c_alu_xor;
            3'b101:  w_alu_ri = Funct7b5 ? c_alu_sra : c_alu_srl;
            3'b110:  w_alu_ri = c_alu_or;
            default: w_alu_ri = c_alu_and;
        endcase
    end

    always_comb begin
        w_taken    = 1'b0;
        w_br_legal = 1'b1;
        case (Funct3)
            3'b000:         w_taken = Zero;
            3'b001:         w_taken = !Zero;
            3'b100, 3'b110: w_taken = AluLt;
            3'b101, 3'b111: w_taken = !AluLt;
            default:        w_br_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next    = r_state;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ImmSrc    = 3'b000;
        w_alu     = c_alu_add;
        InstrDone = 1'b0;
        case (r_state)
            c_fetch: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
                if (MemReady) w_next = c_decode;
            end
            c_decode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = (Op == c_op_jal) ? 3'b011 : 3'b010;
                case (Op)
                    c_op_load, c_op_store: w_next = c_memadr;
                    c_op_rtype:            w_next = c_execr;
                    c_op_itype:            w_next = c_execi;
                    c_op_lui:              w_next = c_lui;
                    c_op_auipc:            w_next = c_auipc;
                    c_op_jal:              w_next = c_jal;
                    c_op_jalr:             w_next = c_jalr_adr;
                    c_op_branch:           w_next = c_branch;
                    default:               w_next = c_trap;
                endcase
            end
            c_memadr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = Op[5] ? 3'b001 : 3'b000;
                w_next  = Op[5] ? c_memwrite : c_memread;
            end
            c_memread: begin
                AdrSrc = 1'b1;
                if (MemReady) w_next = c_memwb;
            end
            c_memwb: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
                w_next    = c_fetch;
            end
            c_memwrite: begin
                AdrSrc    = 1'b1;
                MemWrite  = 1'b1;
                InstrDone = MemReady;
                if (MemReady) w_next = c_fetch;
            end
            c_execr: begin
                ALUSrcA = 2'b10;
                w_alu   = w_alu_ri;
                w_next  = c_aluwb;
            end
            c_execi: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_alu   = w_alu_ri;
                w_next  = c_aluwb;
            end
            c_lui: begin
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b100;
                w_alu   = c_alu_pass;
                w_next  = c_aluwb;
            end
            c_auipc: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b100;
                w_next  = c_aluwb;
            end
            c_aluwb: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
                w_next    = c_fetch;
            end
            // PC loads the target held in ALUOut while the ALU forms OldPC+4 for rd.
            c_jal, c_jalr_j: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                w_next  = c_aluwb;
            end
            c_jalr_adr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = c_jalr_j;
            end
            c_branch: begin
                ALUSrcA   = 2'b10;
                w_alu     = Funct3[2] ? (Funct3[1] ? c_alu_sltu : c_alu_slt) : c_alu_sub;
                PCWrite   = w_br_legal && w_taken;
                InstrDone = w_br_legal;
                w_next    = w_br_legal ? c_fetch : c_trap;
            end
            default: begin
                w_next = c_trap;
            end
        endcase
    end

    assign ALUControl = ALU_CTRL_WIDTH'(w_alu);
    assign Illegal    = (r_state == c_trap);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Self-checking bench for multicycle_ctrl against a step-list model.
// Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] Op;
    logic [2:0] Funct3;
    logic       Funct7b5, Zero, AluLt, MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, InstrDone, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl #(.ALU_CTRL_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .Funct3(Funct3), .Funct7b5(Funct7b5),
        .Zero(Zero), .AluLt(AluLt), .MemReady(MemReady), .PCWrite(PCWrite),
        .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .InstrDone(InstrDone), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    wire [19:0] obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                       ALUSrcA, ALUSrcB, ImmSrc, ALUControl, InstrDone, Illegal};

    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYPE = 7'b0110011;
    localparam logic [6:0] ITYPE = 7'b0010011, LUI = 7'b0110111, AUIPC = 7'b0010111;
    localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, BRANCH = 7'b1100011;
    localparam logic [19:0] FULL = 20'hFFFFF;
    localparam logic [19:0] TRAPV = 20'h00001;

    // Expected per-cycle plan for one instruction.
    logic [19:0] q_v[$];
    logic [19:0] q_m[$];
    bit          q_wait[$];
    bit          q_girpc[$];
    bit          q_gdone[$];
    string       q_tag[$];

    function automatic logic [19:0] ov(input logic pcw, adr, mw, irw, rw,
                                       input logic [1:0] rs, sa, sb,
                                       input logic [2:0] im, input logic [3:0] ac,
                                       input logic done, ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, im, ac, done, ill};
    endfunction

    task automatic push(input logic [19:0] v, input bit w, gi, gd,
                        input logic [19:0] m, input string t);
        q_v.push_back(v); q_wait.push_back(w); q_girpc.push_back(gi);
        q_gdone.push_back(gd); q_m.push_back(m); q_tag.push_back(t);
    endtask

    // Arithmetic meaning of funct3 for OP / OP-IMM; sub is register-only.
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic f7, input bit is_r);
        logic [3:0] tbl [8];
        tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        if (f3 == 3'd0 && f7 && is_r) return 4'd1;
        if (f3 == 3'd5 && f7)         return 4'd7;
        return tbl[f3];
    endfunction

    function automatic bit branch_legal(input logic [2:0] f3);
        return !(f3 == 3'd2 || f3 == 3'd3);
    endfunction

    function automatic int base_cycles(input logic [6:0] op);
        if (op == LOAD || op == JALR) return 5;
        if (op == BRANCH)             return 3;
        return 4;
    endfunction

    task automatic plan_instr(input logic [6:0] op, input logic [2:0] f3,
                              input logic f7, z, lt);
        logic [19:0] aluwb, jump;
        logic        taken;
        q_v.delete(); q_m.delete(); q_wait.delete();
        q_girpc.delete(); q_gdone.delete(); q_tag.delete();
        aluwb = ov(0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'd0, 4'd0, 1, 0);
        jump  = ov(1,0,0,0,0, 2'b00, 2'b01, 2'b10, 3'd0, 4'd0, 0, 0);
        push(ov(0,0,0,0,0, 2'b10, 2'b00, 2'b10, 3'd0, 4'd0, 0, 0), 1, 1, 0, FULL, "fetch");
        push(ov(0,0,0,0,0, 2'b00, 2'b01, 2'b01, (op == JAL) ? 3'd3 : 3'd2, 4'd0, 0, 0),
             0, 0, 0, FULL, "decode");
        case (op)
            LOAD: begin
                push(ov(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'd0, 4'd0, 0, 0), 0, 0, 0, FULL, "memadr_ld");
                push(ov(0,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'd0, 4'd0, 0, 0), 1, 0, 0, FULL, "memread");
                push(ov(0,0,0,0,1, 2'b01, 2'b00, 2'b00, 3'd0, 4'd0, 1, 0), 0, 0, 0, FULL, "memwb");
            end
            STORE: begin
                push(ov(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'd1, 4'd0, 0, 0), 0, 0, 0, FULL, "memadr_st");
                push(ov(0,1,1,0,0, 2'b00, 2'b00, 2'b00, 3'd0, 4'd0, 0, 0), 1, 0, 1, FULL, "memwrite");
            end
            RTYPE: begin
                push(ov(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'd0, arith_op(f3, f7, 1), 0, 0), 0, 0, 0, FULL, "execr");
                push(aluwb, 0, 0, 0, FULL, "aluwb");
            end
            ITYPE: begin
                push(ov(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'd0, arith_op(f3, f7, 0), 0, 0), 0, 0, 0, FULL, "execi");
                push(aluwb, 0, 0, 0, FULL, "aluwb");
            end
            LUI: begin
                push(ov(0,0,0,0,0, 2'b00, 2'b00, 2'b01, 3'd4, 4'b1011, 0, 0), 0, 0, 0, FULL, "lui");
                push(aluwb, 0, 0, 0, FULL, "aluwb");
            end
            AUIPC: begin
                push(ov(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'd4, 4'd0, 0, 0), 0, 0, 0, FULL, "auipc");
                push(aluwb, 0, 0, 0, FULL, "aluwb");
            end
            JAL: begin
                push(jump, 0, 0, 0, FULL, "jal");
                push(aluwb, 0, 0, 0, FULL, "aluwb");
            end
            JALR: begin
                push(ov(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'd0, 4'd0, 0, 0), 0, 0, 0, FULL, "jalr_adr");
                push(jump, 0, 0, 0, FULL, "jalr_j");
                push(aluwb, 0, 0, 0, FULL, "aluwb");
            end
            BRANCH: begin
                // beq/blt/bltu test the condition, their odd-funct3 twins test its negation
                taken = (f3[2] ? lt : z) ^ f3[0];
                if (branch_legal(f3))
                    push(ov(taken,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'd0,
                            f3[2] ? (f3[1] ? 4'd4 : 4'd3) : 4'd1, 1, 0), 0, 0, 0, FULL, "branch");
                else begin
                    push(20'h0, 0, 0, 0, 20'h80001, "branch_bad");
                    push(TRAPV, 0, 0, 0, FULL, "trap");
                end
            end
            default: push(TRAPV, 0, 0, 0, FULL, "trap");
        endcase
    endtask

    task automatic chk(input string tag, input logic [19:0] o, e, m);
        checks++;
        assert ((o & m) === (e & m)) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, o & m, e & m);
        end
    endtask

    task automatic chk_int(input string tag, input int o, e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    // Steps through the plan; wait states see 'lows' not-ready cycles first.
    task automatic run_plan(input int fetch_lows, mem_lows, output int cycles, dones);
        logic [19:0] e;
        logic        rdy;
        int          lows;
        cycles = 0;
        dones  = 0;
        for (int i = 0; i < q_v.size(); i++) begin
            lows = q_wait[i] ? ((i == 0) ? fetch_lows : mem_lows) : 0;
            for (int k = 0; k <= lows; k++) begin
                rdy = q_wait[i] ? (k == lows) : 1'($urandom_range(0, 1));
                MemReady = rdy;
                e = q_v[i];
                if (q_girpc[i]) begin e[19] = rdy; e[16] = rdy; end
                if (q_gdone[i]) e[1] = rdy;
                @(negedge clk);
                chk(q_tag[i], obs, e, q_m[i]);
                cycles++;
                if (InstrDone) dones++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, z, lt, input int fl, ml, input string tag);
        int cyc, dn;
        Op = op; Funct3 = f3; Funct7b5 = f7; Zero = z; AluLt = lt;
        plan_instr(op, f3, f7, z, lt);
        run_plan(fl, ml, cyc, dn);
        chk_int({tag, "_cycles"}, cyc,
                base_cycles(op) + fl + ((op == LOAD || op == STORE) ? ml : 0));
        chk_int({tag, "_done"}, dn, 1);
    endtask

    task automatic trap_and_reset(input string tag);
        int cyc, dn;
        run_plan(0, 0, cyc, dn);
        for (int i = 0; i < 9; i++) begin
            MemReady = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk({tag, "_trap_hold"}, obs, TRAPV, FULL);
            @(posedge clk); #1;
        end
        rst_n = 1'b0; MemReady = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk({tag, "_reset"}, obs, ov(0,0,0,0,0, 2'b10, 2'b00, 2'b10, 3'd0, 4'd0, 0, 0), FULL);
        @(posedge clk); #1;
    endtask

    logic [6:0] ops [9];
    logic [6:0] rop;
    logic [2:0] rf3;

    initial begin
        ops = '{LOAD, STORE, RTYPE, ITYPE, LUI, AUIPC, JAL, JALR, BRANCH};
        rst_n = 1'b0; MemReady = 1'b0; Op = 7'd0; Funct3 = 3'd0;
        Funct7b5 = 1'b0; Zero = 1'b0; AluLt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset", obs, ov(0,0,0,0,0, 2'b10, 2'b00, 2'b10, 3'd0, 4'd0, 0, 0), FULL);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_instr(RTYPE, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, "add");
        run_instr(RTYPE, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0, "sub");
        run_instr(LOAD,  3'd2, 1'b0, 1'b0, 1'b0, 0, 3, "lw_wait");
        run_instr(BRANCH, 3'd0, 1'b0, 1'b1, 1'b0, 0, 0, "beq_taken");
        run_instr(BRANCH, 3'd5, 1'b0, 1'b0, 1'b1, 0, 0, "bge_not_taken");
        run_instr(ITYPE, 3'd5, 1'b1, 1'b0, 1'b0, 0, 0, "srai");
        run_instr(ITYPE, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0, "addi_f7");
        run_instr(LUI,   3'd0, 1'b0, 1'b0, 1'b0, 0, 0, "lui");
        run_instr(STORE, 3'd2, 1'b0, 1'b0, 1'b0, 2, 2, "sw_wait");

        for (int n = 0; n < 60; n++) begin
            rop = ops[$urandom_range(0, 8)];
            do rf3 = 3'($urandom_range(0, 7));
            while (rop == BRANCH && !branch_legal(rf3));
            run_instr(rop, rf3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2),
                      "rand");
        end

        Op = BRANCH; Funct3 = 3'd2; Funct7b5 = 1'b0; Zero = 1'b1; AluLt = 1'b1;
        plan_instr(BRANCH, 3'd2, 1'b0, 1'b1, 1'b1);
        trap_and_reset("bad_branch");

        Op = 7'b1111111; Funct3 = 3'd0; Zero = 1'b0; AluLt = 1'b0;
        plan_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 1'b0);
        trap_and_reset("bad_op");

        run_instr(JALR, 3'd0, 1'b0, 1'b0, 1'b0, 1, 0, "jalr_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
